// File: rtl/level_cond_pkg.sv
// level_cond_pkg: shared types and default constants for the level sensor
// conditioner.
//   fault_state_t     : states of the inconsistent-sensor fault FSM
//   *_DEF             : default parameter values used by the conditioner
package level_cond_pkg;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        FAULT   = 2'd2
    } fault_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int FAULT_CYCLES_DEF    = 8;
    localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/level_debounce_ch.sv
// level_debounce_ch: one sensor channel -- two-flop synchroniser followed by
// a debounce counter. The output follows the synced input only after the new
// level has persisted for DEBOUNCE_CYCLES consecutive synced cycles.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   raw_i  in  asynchronous raw sensor level
//   lvl_o  out debounced level
//   chg_o  out one-cycle pulse on the edge lvl_o toggles
module level_debounce_ch
    import level_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic lvl_o,
    output logic chg_o
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1) begin : g_param_chk
        $fatal(1, "level_debounce_ch: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             lvl_q, lvl_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Restart on any agreement with the held level, so a reversal always
    // begins a fresh count. The >= compare keeps the counter from wrapping.
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        chg_d = 1'b0;
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_MAX) begin
            lvl_d = s2_q;
            cnt_d = '0;
            chg_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
            lvl_q <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
            chg_q <= chg_d;
        end
    end

    assign lvl_o = lvl_q;
    assign chg_o = chg_q;

endmodule

// File: rtl/level_sensor_conditioner.sv
// level_sensor_conditioner: turns the raw bottom/top tank sensors into clean
// debounced Bot/Top levels, pulses on each level change, and raises a sticky
// fault when the debounced top sensor reads wet while the bottom reads dry.
// Build option: define LEVEL_FAULT_MASK_EN to force Bot/Top to 1,1 (tank
// full, pump off) while the fault is set; otherwise fault is indication only.
// Ports:
//   clk        in  rising-edge clock
//   rst_n      in  asynchronous active-low reset
//   raw_bot    in  raw bottom sensor (1 = wet), asynchronous
//   raw_top    in  raw top sensor (1 = wet), asynchronous
//   fault_clr  in  single-cycle request to clear a sticky fault
//   Bot, Top   out debounced levels for the downstream level decoder
//   bot_chg    out pulse on the edge the internal bottom level toggles
//   top_chg    out pulse on the edge the internal top level toggles
//   fault      out sticky inconsistent-sensor flag
module level_sensor_conditioner
    import level_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int FAULT_CYCLES    = FAULT_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_bot,
    input  logic raw_top,
    input  logic fault_clr,
    output logic Bot,
    output logic Top,
    output logic bot_chg,
    output logic top_chg,
    output logic fault
);

    if (FAULT_CYCLES < 1 || FAULT_CYCLES > (1 << CNT_W) - 1) begin : g_param_chk
        $fatal(1, "level_sensor_conditioner: FAULT_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] FCNT_MAX = CNT_W'(FAULT_CYCLES - 1);

    logic bot_lvl, top_lvl;

    level_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_bot (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (raw_bot),
        .lvl_o (bot_lvl),
        .chg_o (bot_chg)
    );

    level_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_top (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (raw_top),
        .lvl_o (top_lvl),
        .chg_o (top_chg)
    );

    fault_state_t     state_q, state_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             fault_q, fault_d;
    logic             bad;

    // Water at the top with a dry bottom cannot happen physically.
    assign bad = top_lvl & ~bot_lvl;

    // fcnt counts edges with bad seen; entering SUSPECT already counts one.
    // The >= compare also covers FAULT_CYCLES=1 (fcnt starts above the limit).
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        fault_d = fault_q;
        case (state_q)
            OK: begin
                if (bad) begin
                    state_d = SUSPECT;
                    fcnt_d  = CNT_W'(1);
                end
            end
            SUSPECT: begin
                if (!bad) begin
                    state_d = OK;
                    fcnt_d  = '0;
                end else if (fcnt_q >= FCNT_MAX) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else if (fcnt_q != '1) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            FAULT: begin
                fault_d = 1'b1;
                // A clear is only honoured once the sensors agree again.
                if (fault_clr && !bad) begin
                    state_d = OK;
                    fault_d = 1'b0;
                    fcnt_d  = '0;
                end
            end
            default: begin
                state_d = OK;
                fault_d = 1'b0;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OK;
            fcnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

`ifdef LEVEL_FAULT_MASK_EN
    // Report "full" while faulted so the downstream pump stays off.
    assign Bot = bot_lvl | fault_q;
    assign Top = top_lvl | fault_q;
`else
    assign Bot = bot_lvl;
    assign Top = top_lvl;
`endif

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Directed bench for level_sensor_conditioner at default parameters
// (DEBOUNCE_CYCLES=4, FAULT_CYCLES=8). Inputs change and outputs are sampled
// 1 time unit after a rising edge. Expected Bot/Top during a fault follow
// the LEVEL_FAULT_MASK_EN build option.
module tb_level_sensor_conditioner;

`ifdef LEVEL_FAULT_MASK_EN
    localparam logic MASK = 1'b1;
`else
    localparam logic MASK = 1'b0;
`endif

    logic clk, rst_n, raw_bot, raw_top, fault_clr;
    logic Bot, Top, bot_chg, top_chg, fault;

    int ncomp = 0;
    int nfail = 0;

    level_sensor_conditioner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_bot   (raw_bot),
        .raw_top   (raw_top),
        .fault_clr (fault_clr),
        .Bot       (Bot),
        .Top       (Top),
        .bot_chg   (bot_chg),
        .top_chg   (top_chg),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic seen_top, seen_tchg;

    initial begin
        rst_n = 1'b0; raw_bot = 1'b0; raw_top = 1'b0; fault_clr = 1'b0;
        #1;
        chk("rst_Bot", Bot, 1'b0);
        chk("rst_Top", Top, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_bchg", bot_chg, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Debounce pass: sampled first at edge E, Bot rises at E+5.
        raw_bot = 1'b1;
        tick(5);                               // E..E+4
        chk("deb_Bot_E4", Bot, 1'b0);
        chk("deb_bchg_E4", bot_chg, 1'b0);
        tick(1);                               // E+5
        chk("deb_Bot_E5", Bot, 1'b1);
        chk("deb_bchg_E5", bot_chg, 1'b1);
        tick(1);                               // E+6
        chk("deb_bchg_E6", bot_chg, 1'b0);
        chk("deb_Bot_E6", Bot, 1'b1);

        // Asynchronous reset between edges clears Bot without a clock.
        #3 rst_n = 1'b0;
        #1;
        chk("arst_Bot", Bot, 1'b0);
        chk("arst_bchg", bot_chg, 1'b0);
        chk("arst_fault", fault, 1'b0);
        tick(1);
        rst_n = 1'b1;                          // raw_bot still 1: re-debounce
        tick(5);
        chk("rearm_Bot_5", Bot, 1'b0);
        tick(1);
        chk("rearm_Bot_6", Bot, 1'b1);
        chk("rearm_bchg", bot_chg, 1'b1);

        // Glitch: 3 synced cycles of top wet must never reach Top.
        raw_top = 1'b1;
        tick(3);
        raw_top = 1'b0;
        seen_top = 1'b0; seen_tchg = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen_top  = seen_top  | Top;
            seen_tchg = seen_tchg | top_chg;
        end
        chk("glitch_Top", seen_top, 1'b0);
        chk("glitch_tchg", seen_tchg, 1'b0);

        // Bring bottom back dry, then both wet together.
        raw_bot = 1'b0;
        tick(6);
        chk("bot_fall", Bot, 1'b0);
        chk("bot_fall_chg", bot_chg, 1'b1);
        tick(2);
        raw_bot = 1'b1; raw_top = 1'b1;
        tick(5);
        chk("sim_Bot_E4", Bot, 1'b0);
        chk("sim_Top_E4", Top, 1'b0);
        tick(1);
        chk("sim_Bot", Bot, 1'b1);
        chk("sim_Top", Top, 1'b1);
        chk("sim_bchg", bot_chg, 1'b1);
        chk("sim_tchg", top_chg, 1'b1);
        tick(2);

        // Near miss: bottom dry for 7 edges only (Bot=0 at T, back at T+7).
        raw_bot = 1'b0;
        tick(6);                               // T
        chk("nm_Bot_T", Bot, 1'b0);
        tick(1);                               // T+1
        raw_bot = 1'b1;
        tick(6);                               // T+7
        chk("nm_Bot_T7", Bot, 1'b1);
        tick(4);
        chk("nm_fault", fault, 1'b0);

        // Real fault: Bot=0 at T, fault rises at T+8.
        raw_bot = 1'b0;
        tick(6);                               // T
        chk("f_Bot_T", Bot, 1'b0);
        tick(7);                               // T+7
        chk("f_fault_T7", fault, 1'b0);
        tick(1);                               // T+8
        chk("f_fault_T8", fault, 1'b1);
        chk("f_Bot_mask", Bot, MASK);
        chk("f_Top_mask", Top, 1'b1);

        // Clear while still inconsistent is ignored.
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        chk("clr_bad_fault", fault, 1'b1);
        tick(1);
        chk("clr_bad_fault2", fault, 1'b1);

        // Bottom wet again: fault stays sticky, then clear takes effect.
        raw_bot = 1'b1;
        tick(6);
        chk("fix_bchg", bot_chg, 1'b1);
        chk("fix_Bot", Bot, 1'b1);
        chk("fix_fault_sticky", fault, 1'b1);
        tick(1);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        chk("clr_ok_fault", fault, 1'b0);
        chk("clr_ok_Bot", Bot, 1'b1);
        chk("clr_ok_Top", Top, 1'b1);

        // Drop top: after clear outputs follow debounced values again.
        raw_top = 1'b0;
        tick(6);
        chk("end_Top", Top, 1'b0);
        chk("end_tchg", top_chg, 1'b1);
        chk("end_fault", fault, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
